// File: rtl/ctrl_pkg.sv
// Shared types for the control unit: opcodes, FSM states,
// branch condition codes and the datapath strobe bundle.
package ctrl_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'h0,
      OP_ALU   = 4'h1,
      OP_ALUI  = 4'h2,
      OP_LDI   = 4'h3,
      OP_LOAD  = 4'h4,
      OP_STORE = 4'h5,
      OP_PUSH  = 4'h6,
      OP_HALT  = 4'h7,
      OP_POP   = 4'h8,
      OP_JMP   = 4'h9,
      OP_CALL  = 4'hA,
      OP_RET   = 4'hB,
      OP_RTI   = 4'hC
   } opcode_t;

   typedef enum logic [3:0] {
      FETCH0 = 4'd0,
      FETCH1 = 4'd1,
      EXEC   = 4'd2,
      MEM0   = 4'd3,
      MEM1   = 4'd4,
      IRQ0   = 4'd5,
      IRQ1   = 4'd6,
      HALT   = 4'd7
   } state_t;

   localparam logic [3:0] COND_ALWAYS = 4'd0;
   localparam logic [3:0] COND_Z      = 4'd1;
   localparam logic [3:0] COND_NZ     = 4'd2;
   localparam logic [3:0] COND_N      = 4'd3;
   localparam logic [3:0] COND_NN     = 4'd4;
   localparam logic [3:0] COND_LE     = 4'd5;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_read_is_pc;
      logic mem_read_is_sp;
      logic alu_override_imm8;
      logic alu_override_imm4;
      logic alu_set_flags;
      logic set_pc;
      logic pc_from_register;
      logic pc_from_irq;
      logic pc_from_mem;
      logic mem_write;
      logic mem_write_is_stack;
      logic mem_write_next_pc;
      logic mem_write_this_pc;
      logic set_sp;
      logic increase_sp;
      logic reset_irq;
   } strobes_t;

endpackage

// File: rtl/control_unit_branch_cond.sv
// Branch condition evaluation from the Z/N flags.
module branch_cond
   import ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic       z,
   input  logic       n,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      unique case (cond)
         COND_ALWAYS: taken = 1'b1;
         COND_Z:      taken = z;
         COND_NZ:     taken = ~z;
         COND_N:      taken = n;
         COND_NN:     taken = ~n;
         COND_LE:     taken = n | z;
         default:     taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetch/exec/mem phases, stack ops,
// branches, interrupt entry/return and halt.
module control_unit
   import ctrl_pkg::*;
#(
   parameter logic [3:0] IRQ_VECTOR_REG = 4'hC,
   parameter logic       RESET_IE       = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] current_instruction,
   input  logic        Z_out,
   input  logic        N_out,
   input  logic        irq,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        mem_read_is_pc,
   output logic        mem_read_is_sp,
   output logic        alu_override_imm8,
   output logic        alu_override_imm4,
   output logic        alu_set_flags,
   output logic        set_pc,
   output logic        pc_from_register,
   output logic        pc_from_irq,
   output logic        pc_from_mem,
   output logic        mem_write,
   output logic        mem_write_is_stack,
   output logic        mem_write_next_pc,
   output logic        mem_write_this_pc,
   output logic        set_sp,
   output logic        increase_sp,
   output logic        reset_irq,
   output logic        halted,
   output logic        ie,
   output logic [3:0]  state_poke
);

   state_t     state;
   strobes_t   s;
   logic [3:0] op;
   logic       taken;
   logic       irq_go;
   logic       has_mem;
   logic       stack_rd;
   logic       unused_ins;

   assign op         = current_instruction[15:12];
   assign irq_go     = irq & ie;
   assign has_mem    = op inside {OP_LOAD, OP_POP, OP_RET, OP_RTI};
   assign stack_rd   = op inside {OP_POP, OP_RET, OP_RTI};
   assign unused_ins = ^current_instruction[11:4];

   branch_cond u_cond (
      .cond  (current_instruction[3:0]),
      .z     (Z_out),
      .n     (N_out),
      .taken (taken)
   );

   // irq is only looked at on instruction boundaries and in HALT
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= FETCH0;
         ie    <= RESET_IE;
      end else begin
         unique case (state)
            FETCH0: state <= FETCH1;
            FETCH1: state <= EXEC;
            EXEC: begin
               if (op == OP_HALT)
                  state <= HALT;
               else if (has_mem)
                  state <= MEM0;
               else
                  state <= irq_go ? IRQ0 : FETCH0;
            end
            MEM0: state <= MEM1;
            MEM1: begin
               if (op == OP_RTI)
                  ie <= 1'b1;
               state <= irq_go ? IRQ0 : FETCH0;
            end
            IRQ0: state <= IRQ1;
            IRQ1: begin
               ie    <= 1'b0;
               state <= FETCH0;
            end
            HALT: begin
               if (irq_go)
                  state <= IRQ0;
            end
            default: state <= FETCH0;
         endcase
      end
   end

   always_comb begin
      s = '0;
      if (reset) begin
         unique case (state)
            FETCH0: s.mem_read_is_pc = 1'b1;
            FETCH1: begin
               s.mem_read_is_pc = 1'b1;
               s.set_pc         = 1'b1;
            end
            EXEC: begin
               unique case (op)
                  OP_ALU: begin
                     s.reg_write     = 1'b1;
                     s.alu_set_flags = 1'b1;
                  end
                  OP_ALUI: begin
                     s.reg_write         = 1'b1;
                     s.alu_set_flags     = 1'b1;
                     s.alu_override_imm4 = 1'b1;
                  end
                  OP_LDI: begin
                     s.reg_write         = 1'b1;
                     s.alu_override_imm8 = 1'b1;
                  end
                  OP_STORE: s.mem_write = 1'b1;
                  OP_PUSH: begin
                     s.mem_write          = 1'b1;
                     s.mem_write_is_stack = 1'b1;
                     s.set_sp             = 1'b1;
                  end
                  OP_POP, OP_RET, OP_RTI: begin
                     s.set_sp      = 1'b1;
                     s.increase_sp = 1'b1;
                  end
                  OP_JMP: begin
                     s.set_pc           = taken;
                     s.pc_from_register = taken;
                  end
                  OP_CALL: begin
                     s.mem_write          = 1'b1;
                     s.mem_write_is_stack = 1'b1;
                     s.mem_write_next_pc  = 1'b1;
                     s.set_sp             = 1'b1;
                     s.set_pc             = 1'b1;
                     s.pc_from_register   = 1'b1;
                  end
                  default: s = '0;
               endcase
            end
            MEM0: s.mem_read_is_sp = stack_rd;
            MEM1: begin
               s.mem_read_is_sp = stack_rd;
               if (op == OP_LOAD || op == OP_POP) begin
                  s.reg_write  = 1'b1;
                  s.mem_to_reg = 1'b1;
               end
               if (op == OP_RET || op == OP_RTI) begin
                  s.set_pc      = 1'b1;
                  s.pc_from_mem = 1'b1;
               end
            end
            IRQ0: begin
               s.mem_write          = 1'b1;
               s.mem_write_is_stack = 1'b1;
               s.mem_write_this_pc  = 1'b1;
               s.set_sp             = 1'b1;
            end
            IRQ1: begin
               s.set_pc           = 1'b1;
               s.pc_from_irq      = 1'b1;
               s.pc_from_register = 1'b1;
               s.reset_irq        = 1'b1;
            end
            default: s = '0;
         endcase
      end
   end

   assign reg_write          = s.reg_write;
   assign mem_to_reg         = s.mem_to_reg;
   assign mem_read_is_pc     = s.mem_read_is_pc;
   assign mem_read_is_sp     = s.mem_read_is_sp;
   assign alu_override_imm8  = s.alu_override_imm8;
   assign alu_override_imm4  = s.alu_override_imm4;
   assign alu_set_flags      = s.alu_set_flags;
   assign set_pc             = s.set_pc;
   assign pc_from_register   = s.pc_from_register;
   assign pc_from_irq        = s.pc_from_irq;
   assign pc_from_mem        = s.pc_from_mem;
   assign mem_write          = s.mem_write;
   assign mem_write_is_stack = s.mem_write_is_stack;
   assign mem_write_next_pc  = s.mem_write_next_pc;
   assign mem_write_this_pc  = s.mem_write_this_pc;
   assign set_sp             = s.set_sp;
   assign increase_sp        = s.increase_sp;
   assign reset_irq          = s.reset_irq;
   assign halted             = (state == HALT);
   assign state_poke         = state;

   // ISR address is read from a fixed register selected via pc_from_register
   always_ff @(posedge clock) begin
      if (reset) begin
         assert (!(s.mem_write && s.reg_write));
         assert (!(s.pc_from_mem && s.pc_from_register));
         assert (!s.pc_from_irq ||
                 (s.pc_from_register && IRQ_VECTOR_REG != 4'h0));
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit with a cycle-trace
// reference model derived from the instruction timing rules.
module tb_control_unit;

   localparam int F0 = 0, F1 = 1, EX = 2, M0 = 3;
   localparam int M1 = 4, I0 = 5, I1 = 6, HL = 7;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] current_instruction = 16'h0;
   logic        Z_out = 1'b0;
   logic        N_out = 1'b0;
   logic        irq = 1'b0;
   logic        reg_write, mem_to_reg, mem_read_is_pc, mem_read_is_sp;
   logic        alu_override_imm8, alu_override_imm4, alu_set_flags;
   logic        set_pc, pc_from_register, pc_from_irq, pc_from_mem;
   logic        mem_write, mem_write_is_stack, mem_write_next_pc;
   logic        mem_write_this_pc, set_sp, increase_sp, reset_irq;
   logic        halted, ie;
   logic [3:0]  state_poke;

   int n_cmp = 0;
   int n_bad = 0;
   int ie_m  = 0;
   int setpc_cnt = 0;

   always #5 clock = ~clock;

   control_unit dut (
      .clock               (clock),
      .reset               (reset),
      .current_instruction (current_instruction),
      .Z_out               (Z_out),
      .N_out               (N_out),
      .irq                 (irq),
      .reg_write           (reg_write),
      .mem_to_reg          (mem_to_reg),
      .mem_read_is_pc      (mem_read_is_pc),
      .mem_read_is_sp      (mem_read_is_sp),
      .alu_override_imm8   (alu_override_imm8),
      .alu_override_imm4   (alu_override_imm4),
      .alu_set_flags       (alu_set_flags),
      .set_pc              (set_pc),
      .pc_from_register    (pc_from_register),
      .pc_from_irq         (pc_from_irq),
      .pc_from_mem         (pc_from_mem),
      .mem_write           (mem_write),
      .mem_write_is_stack  (mem_write_is_stack),
      .mem_write_next_pc   (mem_write_next_pc),
      .mem_write_this_pc   (mem_write_this_pc),
      .set_sp              (set_sp),
      .increase_sp         (increase_sp),
      .reset_irq           (reset_irq),
      .halted              (halted),
      .ie                  (ie),
      .state_poke          (state_poke)
   );

   logic [17:0] sb;
   assign sb = {reset_irq, increase_sp, set_sp, mem_write_this_pc,
                mem_write_next_pc, mem_write_is_stack, mem_write,
                pc_from_mem, pc_from_irq, pc_from_register, set_pc,
                alu_set_flags, alu_override_imm4, alu_override_imm8,
                mem_read_is_sp, mem_read_is_pc, mem_to_reg, reg_write};

   // Expected strobe word for a given phase of an instruction
   function automatic logic [17:0] exp_sb(int st, logic [15:0] ins,
                                         logic z, logic n);
      logic [17:0] e;
      int op;
      bit tk;
      e  = '0;
      op = int'(ins[15:12]);
      case (ins[3:0])
         4'd0:    tk = 1'b1;
         4'd1:    tk = z;
         4'd2:    tk = !z;
         4'd3:    tk = n;
         4'd4:    tk = !n;
         4'd5:    tk = n | z;
         default: tk = 1'b0;
      endcase
      case (st)
         F0: e[2] = 1'b1;
         F1: begin e[2] = 1'b1; e[7] = 1'b1; end
         EX: begin
            case (op)
               1: begin e[0] = 1; e[6] = 1; end
               2: begin e[0] = 1; e[6] = 1; e[5] = 1; end
               3: begin e[0] = 1; e[4] = 1; end
               5: e[11] = 1;
               6: begin e[11] = 1; e[12] = 1; e[15] = 1; end
               8, 11, 12: begin e[15] = 1; e[16] = 1; end
               9: begin e[7] = tk; e[8] = tk; end
               10: begin
                  e[11] = 1; e[12] = 1; e[13] = 1;
                  e[15] = 1; e[7] = 1; e[8] = 1;
               end
               default: e = '0;
            endcase
         end
         M0: e[3] = (op == 8 || op == 11 || op == 12);
         M1: begin
            e[3] = (op == 8 || op == 11 || op == 12);
            if (op == 4 || op == 8) begin e[0] = 1; e[1] = 1; end
            if (op == 11 || op == 12) begin e[7] = 1; e[10] = 1; end
         end
         I0: begin e[11] = 1; e[12] = 1; e[14] = 1; e[15] = 1; end
         I1: begin e[7] = 1; e[9] = 1; e[8] = 1; e[17] = 1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   // Runs one non-HALT instruction from FETCH0; irq is held high
   // from phase index irq_from onward.
   task automatic run_instr(input logic [15:0] ins, input logic z,
                            input logic n, input int irq_from,
                            input string nm);
      int st_q[$];
      int op;
      int last;
      op   = int'(ins[15:12]);
      st_q = '{F0, F1, EX};
      if (op == 4 || op == 8 || op == 11 || op == 12) begin
         st_q.push_back(M0);
         st_q.push_back(M1);
      end
      last = st_q.size() - 1;
      if (last >= irq_from && ie_m != 0) begin
         st_q.push_back(I0);
         st_q.push_back(I1);
      end
      foreach (st_q[i]) begin
         current_instruction = ins;
         Z_out = z;
         N_out = n;
         irq   = (i >= irq_from);
         #1;
         n_cmp++;
         if (state_poke !== 4'(st_q[i])) begin
            n_bad++;
            $display("FAIL %s state cyc%0d: got %0d want %0d",
                     nm, i, state_poke, st_q[i]);
         end
         n_cmp++;
         if (sb !== exp_sb(st_q[i], ins, z, n)) begin
            n_bad++;
            $display("FAIL %s strobes cyc%0d: got %b want %b",
                     nm, i, sb, exp_sb(st_q[i], ins, z, n));
         end
         n_cmp++;
         if (halted !== 1'b0 || ie !== 1'(ie_m)) begin
            n_bad++;
            $display("FAIL %s halted/ie cyc%0d: got %b/%b want 0/%0d",
                     nm, i, halted, ie, ie_m);
         end
         if (set_pc === 1'b1) setpc_cnt++;
         if (st_q[i] == M1 && op == 12) ie_m = 1;
         if (st_q[i] == I1) ie_m = 0;
         @(negedge clock);
      end
      irq = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if (state_poke !== 4'd0 || sb !== '0 ||
          halted !== 1'b0 || ie !== 1'b0) begin
         n_bad++;
         $display("FAIL reset: state %0d sb %b h %b ie %b, want 0/0/0/0",
                  state_poke, sb, halted, ie);
      end
      @(negedge clock);
      reset = 1'b1;
      ie_m  = 0;
   endtask

   task automatic test_ldi();
      setpc_cnt = 0;
      run_instr(16'h3105, 1'b0, 1'b0, 99, "ldi");
      n_cmp++;
      if (setpc_cnt != 1) begin
         n_bad++;
         $display("FAIL ldi set_pc pulses: got %0d want 1", setpc_cnt);
      end
   endtask

   task automatic test_jmp();
      run_instr(16'h9201, 1'b0, 1'b0, 99, "jmp_nz");
      run_instr(16'h9201, 1'b1, 1'b0, 99, "jmp_z");
      run_instr(16'h9205, 1'b0, 1'b1, 99, "jmp_le");
      run_instr(16'h9207, 1'b1, 1'b1, 99, "jmp_never");
   endtask

   task automatic test_push_pop();
      run_instr(16'h6030, 1'b0, 1'b0, 99, "push");
      run_instr(16'h8100, 1'b0, 1'b0, 99, "pop");
      run_instr(16'hA400, 1'b0, 1'b0, 99, "call");
      run_instr(16'hB000, 1'b0, 1'b0, 99, "ret");
   endtask

   task automatic test_rti();
      run_instr(16'hC000, 1'b0, 1'b0, 99, "rti");
      n_cmp++;
      if (ie !== 1'b1) begin
         n_bad++;
         $display("FAIL rti ie: got %b want 1", ie);
      end
   endtask

   task automatic test_irq_load();
      run_instr(16'h4120, 1'b0, 1'b0, 3, "irq_load");
      n_cmp++;
      if (ie !== 1'b0 || state_poke !== 4'd0) begin
         n_bad++;
         $display("FAIL irq_load after: ie %b st %0d want 0/0",
                  ie, state_poke);
      end
   endtask

   task automatic test_halt_irq();
      int st_q[$];
      run_instr(16'hC000, 1'b0, 1'b0, 99, "halt_irq_rti");
      st_q = '{F0, F1, EX, HL, HL, HL, HL, I0, I1, F0};
      foreach (st_q[i]) begin
         current_instruction = 16'h7000;
         irq = (i >= 6);
         #1;
         n_cmp++;
         if (state_poke !== 4'(st_q[i]) ||
             sb !== exp_sb(st_q[i], 16'h7000, 1'b0, 1'b0) ||
             halted !== 1'(st_q[i] == HL) || ie !== 1'(ie_m)) begin
            n_bad++;
            $display("FAIL halt_irq cyc%0d: st %0d sb %b h %b ie %b want st %0d",
                     i, state_poke, sb, halted, ie, st_q[i]);
         end
         if (st_q[i] == I1) ie_m = 0;
         if (i < st_q.size() - 1) @(negedge clock);
      end
      irq = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] ins;
      int op, irq_from;
      logic z, n;
      for (int k = 0; k < 60; k++) begin
         do op = int'($urandom_range(0, 15)); while (op == 7);
         ins = {4'(op), 12'($urandom)};
         z = 1'($urandom);
         n = 1'($urandom);
         if (op == 12 || $urandom_range(0, 1) == 0)
            irq_from = 99;
         else
            irq_from = int'($urandom_range(0, 4));
         run_instr(ins, z, n, irq_from, "random");
      end
   endtask

   task automatic test_halt_reset();
      for (int i = 0; i < 8; i++) begin
         current_instruction = 16'h7000;
         irq = 1'b0;
         #1;
         if (i >= 3) begin
            n_cmp++;
            if (state_poke !== 4'd7 || halted !== 1'b1 || sb !== '0) begin
               n_bad++;
               $display("FAIL halt hold cyc%0d: st %0d h %b sb %b",
                        i, state_poke, halted, sb);
            end
         end
         @(negedge clock);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (state_poke !== 4'd0 || halted !== 1'b0 ||
          sb !== '0 || ie !== 1'b0) begin
         n_bad++;
         $display("FAIL async reset: st %0d h %b sb %b ie %b",
                  state_poke, halted, sb, ie);
      end
      @(negedge clock);
      reset = 1'b1;
      ie_m  = 0;
      run_instr(16'h1234, 1'b0, 1'b0, 99, "post_reset_alu");
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_jmp();
      test_push_pop();
      test_rti();
      test_irq_load();
      test_halt_irq();
      test_random();
      test_halt_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
